// File: rtl/ttt_pkg.sv
// Shared types, codes and board helpers for the tic-tac-toe board keeper.
// Square 0 lives in board[17:16], square 8 in board[1:0].
package ttt_pkg;

    localparam int NUM_SQ    = 9;
    localparam int BOARD_W   = 18;
    localparam int NUM_LINES = 8;

    localparam logic [1:0] SQ_EMPTY = 2'b00;
    localparam logic [1:0] SQ_X     = 2'b11;
    localparam logic [1:0] SQ_O     = 2'b01;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        XWIN = 2'd1,
        OWIN = 2'd2,
        DRAW = 2'd3
    } result_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    typedef logic [3:0] sq_idx_t;

    // rows, columns, then the two diagonals
    localparam sq_idx_t LINE_TAB [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] sq_get(
        input logic [BOARD_W-1:0] b,
        input sq_idx_t            s
    );
        logic [1:0] r;
        r = SQ_EMPTY;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (s == 4'(i)) r = b[BOARD_W-1-2*i -: 2];
        end
        return r;
    endfunction

    function automatic logic [BOARD_W-1:0] sq_set(
        input logic [BOARD_W-1:0] b,
        input sq_idx_t            s,
        input logic [1:0]         v
    );
        logic [BOARD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (s == 4'(i)) r[BOARD_W-1-2*i -: 2] = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Flags a line of three squares fully owned by X or by O.
// Purely combinational; one instance per board line.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    output logic       x_line,
    output logic       o_line
);

    assign x_line = (a == SQ_X) && (b == SQ_X) && (c == SQ_X);
    assign o_line = (a == SQ_O) && (b == SQ_O) && (c == SQ_O);

endmodule

// File: rtl/board_keeper.sv
// Sole writer of the tic-tac-toe board: move handshake, turns, outcome.
// Optional one-level undo is built when TTT_UNDO_EN is defined.
module board_keeper
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_new_game,
`ifdef TTT_UNDO_EN
    input  logic        i_undo,
`endif
    input  logic        i_move_valid,
    input  logic [3:0]  i_move_sq,
    output logic        o_move_ready,
    output logic        o_move_ack,
    output logic        o_move_err,
    output logic [17:0] o_board,
    output logic        o_turn,
    output logic [3:0]  o_move_count,
    output logic [1:0]  o_result,
    output logic        o_game_over
);

    state_t               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic                 turn_q, turn_d;
    logic [3:0]           count_q, count_d;
    result_t              result_q, result_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    logic [NUM_LINES-1:0] x_line;
    logic [NUM_LINES-1:0] o_line;
    logic                 legal;
    logic                 x_win;
    logic                 o_win;

`ifdef TTT_UNDO_EN
    logic                 hist_v_q, hist_v_d;
    sq_idx_t              hist_sq_q, hist_sq_d;
    logic                 hist_turn_q, hist_turn_d;
`endif

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        ttt_line_check u_lc (
            .a      (sq_get(board_q, LINE_TAB[g][0])),
            .b      (sq_get(board_q, LINE_TAB[g][1])),
            .c      (sq_get(board_q, LINE_TAB[g][2])),
            .x_line (x_line[g]),
            .o_line (o_line[g])
        );
    end

    // next-state, board update and response pulses
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        count_d  = count_q;
        result_d = result_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
`ifdef TTT_UNDO_EN
        hist_v_d    = hist_v_q;
        hist_sq_d   = hist_sq_q;
        hist_turn_d = hist_turn_q;
`endif
        legal = (i_move_sq <= 4'd8)
             && (sq_get(board_q, i_move_sq) == SQ_EMPTY);
        x_win = |x_line;
        o_win = |o_line;

        if (i_new_game) begin
            state_d  = PLAY;
            board_d  = '0;
            turn_d   = FIRST_PLAYER;
            count_d  = 4'd0;
            result_d = NONE;
`ifdef TTT_UNDO_EN
            hist_v_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (i_move_valid) begin
                        if (legal) begin
                            board_d = sq_set(board_q, i_move_sq,
                                             turn_q ? SQ_O : SQ_X);
                            count_d = count_q + 4'd1;
                            ack_d   = 1'b1;
                            state_d = CHECK;
`ifdef TTT_UNDO_EN
                            hist_v_d    = 1'b1;
                            hist_sq_d   = i_move_sq;
                            hist_turn_d = turn_q;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (x_win) begin
                        result_d = XWIN;
                        state_d  = OVER;
                    end else if (o_win) begin
                        result_d = OWIN;
                        state_d  = OVER;
                    end else if (count_q == 4'd9) begin
                        result_d = DRAW;
                        state_d  = OVER;
                    end else begin
                        result_d = NONE;
                        turn_d   = ~turn_q;
                        state_d  = PLAY;
                    end
                end
                OVER: begin
                end
                default: state_d = PLAY;
            endcase
`ifdef TTT_UNDO_EN
            if (i_undo && ((state_q == OVER) ||
                           (state_q == PLAY && !i_move_valid))) begin
                if (hist_v_q) begin
                    board_d  = sq_set(board_q, hist_sq_q, SQ_EMPTY);
                    turn_d   = hist_turn_q;
                    count_d  = count_q - 4'd1;
                    result_d = NONE;
                    state_d  = PLAY;
                    ack_d    = 1'b1;
                    hist_v_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
`endif
        end
    end

    // state and board registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= PLAY;
            board_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            count_q  <= 4'd0;
            result_q <= NONE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            count_q  <= count_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

`ifdef TTT_UNDO_EN
    // one-level history of the last accepted move
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist_v_q    <= 1'b0;
            hist_sq_q   <= 4'd0;
            hist_turn_q <= 1'b0;
        end else begin
            hist_v_q    <= hist_v_d;
            hist_sq_q   <= hist_sq_d;
            hist_turn_q <= hist_turn_d;
        end
    end
`endif

    assign o_move_ready = (state_q == PLAY);
    assign o_move_ack   = ack_q;
    assign o_move_err   = err_q;
    assign o_board      = board_q;
    assign o_turn       = turn_q;
    assign o_move_count = count_q;
    assign o_result     = result_q;
    assign o_game_over  = (result_q != NONE);

endmodule

// File: tb/tb_board_keeper.sv
// Self-checking bench for board_keeper: directed games plus random play
// against an array-based model of the game rules.
module tb_board_keeper;

    localparam logic FP = 1'b0;
`ifdef TTT_UNDO_EN
    localparam bit UNDO = 1'b1;
`else
    localparam bit UNDO = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_new_game;
    logic        i_move_valid;
    logic [3:0]  i_move_sq;
`ifdef TTT_UNDO_EN
    logic        i_undo;
`endif
    logic        o_move_ready;
    logic        o_move_ack;
    logic        o_move_err;
    logic [17:0] o_board;
    logic        o_turn;
    logic [3:0]  o_move_count;
    logic [1:0]  o_result;
    logic        o_game_over;

    int n_checks = 0;
    int n_errors = 0;

    // model: 0 empty, 1 X, 2 O per square
    int mb [9];
    bit mturn;
    int mcount;
    int mres;
    bit mpend;
    bit mover;
    bit hv;
    int hsq;
    bit hturn;
    bit eack;
    bit eerr;

    board_keeper #(.FIRST_PLAYER(FP)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_new_game   (i_new_game),
`ifdef TTT_UNDO_EN
        .i_undo       (i_undo),
`endif
        .i_move_valid (i_move_valid),
        .i_move_sq    (i_move_sq),
        .o_move_ready (o_move_ready),
        .o_move_ack   (o_move_ack),
        .o_move_err   (o_move_err),
        .o_board      (o_board),
        .o_turn       (o_turn),
        .o_move_count (o_move_count),
        .o_result     (o_result),
        .o_game_over  (o_game_over)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        mturn  = FP;
        mcount = 0;
        mres   = 0;
        mpend  = 0;
        mover  = 0;
        hv     = 0;
        eack   = 0;
        eerr   = 0;
    endtask

    function automatic int owner3(int a, int b, int c);
        if (mb[a] != 0 && mb[a] == mb[b] && mb[a] == mb[c]) return mb[a];
        return 0;
    endfunction

    function automatic int winner();
        int r = 0;
        for (int k = 0; k < 3; k++) begin
            if (owner3(3*k, 3*k+1, 3*k+2) != 0) r = owner3(3*k, 3*k+1, 3*k+2);
            if (owner3(k, k+3, k+6) != 0) r = owner3(k, k+3, k+6);
        end
        if (owner3(0, 4, 8) != 0) r = owner3(0, 4, 8);
        if (owner3(2, 4, 6) != 0) r = owner3(2, 4, 6);
        return r;
    endfunction

    function automatic logic [17:0] enc_board();
        logic [17:0] r = '0;
        for (int i = 0; i < 9; i++) begin
            if (mb[i] == 1) r[17-2*i -: 2] = 2'b11;
            if (mb[i] == 2) r[17-2*i -: 2] = 2'b01;
        end
        return r;
    endfunction

    task automatic model_step(input bit v, input logic [3:0] sq,
                              input bit ng, input bit un);
        int w;
        eack = 0;
        eerr = 0;
        if (ng) begin
            model_reset();
        end else if (mpend) begin
            mpend = 0;
            w = winner();
            if (w != 0) begin
                mres  = w;
                mover = 1;
            end else if (mcount == 9) begin
                mres  = 3;
                mover = 1;
            end else begin
                mturn = ~mturn;
            end
        end else if (!mover && v) begin
            if (sq <= 8 && mb[int'(sq)] == 0) begin
                hv    = 1;
                hsq   = int'(sq);
                hturn = mturn;
                mb[int'(sq)] = mturn ? 2 : 1;
                mcount++;
                eack  = 1;
                mpend = 1;
            end else begin
                eerr = 1;
            end
        end else if (UNDO && un) begin
            if (hv) begin
                mb[hsq] = 0;
                mturn   = hturn;
                mcount--;
                mres    = 0;
                mover   = 0;
                hv      = 0;
                eack    = 1;
            end else begin
                eerr = 1;
            end
        end
    endtask

    task automatic check_all();
        check("board",  o_board,      enc_board());
        check("turn",   o_turn,       mturn);
        check("count",  o_move_count, mcount);
        check("result", o_result,     mres);
        check("over",   o_game_over,  mres != 0);
        check("ready",  o_move_ready, !mpend && !mover);
        check("ack",    o_move_ack,   eack);
        check("err",    o_move_err,   eerr);
    endtask

    task automatic cycle(input bit v, input logic [3:0] sq,
                         input bit ng, input bit un);
        i_move_valid = v;
        i_move_sq    = sq;
        i_new_game   = ng;
`ifdef TTT_UNDO_EN
        i_undo       = un;
`endif
        @(posedge i_clk);
        model_step(v, sq, ng, un);
        @(negedge i_clk);
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic move(input logic [3:0] sq);
        cycle(1'b1, sq, 1'b0, 1'b0);
        if (eack) idle();
    endtask

    task automatic new_game();
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_new_game   = 1'b0;
        i_move_valid = 1'b0;
        i_move_sq    = 4'd0;
`ifdef TTT_UNDO_EN
        i_undo       = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge i_clk);
        check_all();
        i_reset_n = 1'b1;

        // X wins on the diagonal
        move(4'd0); move(4'd1); move(4'd4); move(4'd2); move(4'd8);
        check("xwin_board", o_board, 18'b110101001100000011);
        check("xwin_result", o_result, 2'd1);
        check("xwin_over", o_game_over, 1'b1);
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        check("over_no_ack", o_move_ack | o_move_err, 1'b0);

        // occupied and out-of-range squares
        new_game();
        move(4'd4);
        cycle(1'b1, 4'd4, 1'b0, 1'b0);
        check("dup_err", o_move_err, 1'b1);
        cycle(1'b1, 4'd12, 1'b0, 1'b0);
        check("range_err", o_move_err, 1'b1);
        check("err_count", o_move_count, 4'd1);
        check("err_turn", o_turn, 1'b1);

        // full board with no line
        new_game();
        move(4'd0); move(4'd1); move(4'd2); move(4'd4); move(4'd3);
        move(4'd5); move(4'd7); move(4'd6); move(4'd8);
        check("draw_count", o_move_count, 4'd9);
        check("draw_result", o_result, 2'd3);
        check("draw_ready", o_move_ready, 1'b0);

        // new game beats a simultaneous move, and cancels a pending check
        cycle(1'b1, 4'd0, 1'b1, 1'b0);
        check("ng_board", o_board, 18'd0);
        check("ng_ack", o_move_ack, 1'b0);
        cycle(1'b1, 4'd3, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        check("ng_chk_count", o_move_count, 4'd0);
        check("ng_chk_turn", o_turn, FP);
        move(4'd5);
        check("first_code", o_board[7:6], FP ? 2'b01 : 2'b11);

        // asynchronous reset between edges
        move(4'd0);
        #2 i_reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_board", o_board, 18'd0);
        check("arst_count", o_move_count, 4'd0);
        check("arst_turn", o_turn, FP);
        check("arst_result", o_result, 2'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        cycle(1'b1, 4'd4, 1'b0, 1'b0);
        check("arst_move_ack", o_move_ack, 1'b1);
        idle();

`ifdef TTT_UNDO_EN
        new_game();
        move(4'd4);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        check("undo_ack", o_move_ack, 1'b1);
        check("undo_board", o_board, 18'd0);
        check("undo_count", o_move_count, 4'd0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        check("undo2_err", o_move_err, 1'b1);
        move(4'd0); move(4'd1); move(4'd4); move(4'd2); move(4'd8);
        cycle(1'b0, 4'd0, 1'b0, 1'b1);
        check("undo_over_res", o_result, 2'd0);
        check("undo_over_rdy", o_move_ready, 1'b1);
`endif

        // random play
        new_game();
        for (int n = 0; n < 4000; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 10)),
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
